// File: rtl/bitwise_op_arbiter.sv
// Two-requester round-robin arbiter sharing one NOT/AND/OR/XOR unit with a one-entry result buffer.
// Define BITWISE_ARB_STATS_EN to add per-requester 16-bit grant counters.
module bitwise_op_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req0_valid,
    output logic             io_req0_ready,
    input  logic [1:0]       io_req0_op,
    input  logic [WIDTH-1:0] io_req0_a,
    input  logic [WIDTH-1:0] io_req0_b,
    input  logic             io_req1_valid,
    output logic             io_req1_ready,
    input  logic [1:0]       io_req1_op,
    input  logic [WIDTH-1:0] io_req1_a,
    input  logic [WIDTH-1:0] io_req1_b,
    output logic             io_resp_valid,
    input  logic             io_resp_ready,
    output logic [WIDTH-1:0] io_resp_data,
    output logic             io_resp_id
`ifdef BITWISE_ARB_STATS_EN
    ,
    output logic [15:0]      io_grant_count0,
    output logic [15:0]      io_grant_count1
`endif
);

    logic             resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_id_q;
    logic             last_grant_q;

    logic             can_accept;
    logic             grant_valid;
    logic             grant_id;
    logic             xfer;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    assign can_accept = !resp_valid_q | io_resp_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case ({io_req1_valid, io_req0_valid})
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
            // Under contention the requester that did not win last time goes first.
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end
            default: ;
        endcase
    end

    assign io_req0_ready = can_accept & grant_valid & ~grant_id;
    assign io_req1_ready = can_accept & grant_valid & grant_id;
    assign xfer          = can_accept & grant_valid;

    always_comb begin
        sel_op = grant_id ? io_req1_op : io_req0_op;
        sel_a  = grant_id ? io_req1_a  : io_req0_a;
        sel_b  = grant_id ? io_req1_b  : io_req0_b;
        result = '0;
        case (sel_op)
            2'd0:    result = ~sel_a;
            2'd1:    result = sel_a & sel_b;
            2'd2:    result = sel_a | sel_b;
            default: result = sel_a ^ sel_b;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (xfer) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= result;
            resp_id_q    <= grant_id;
            last_grant_q <= grant_id;
        end else if (io_resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_data  = resp_data_q;
    assign io_resp_id    = resp_id_q;

`ifdef BITWISE_ARB_STATS_EN
    logic [15:0] count0_q;
    logic [15:0] count1_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count0_q <= '0;
            count1_q <= '0;
        end else if (xfer) begin
            if (grant_id) count1_q <= count1_q + 16'd1;
            else          count0_q <= count0_q + 16'd1;
        end
    end

    assign io_grant_count0 = count0_q;
    assign io_grant_count1 = count1_q;
`endif

endmodule
